// File: rtl/fence_t_sequencer.sv
// rtl/fence_t_sequencer.sv - constant-latency fence.t flush sequencer
//
// Purpose: turns one fence.t request from commit into a flush sequence that
// always takes the same number of cycles, whatever is being flushed. The
// only exception is a D$ acknowledge that arrives after the deadline.
// Commit is halted for the whole time the fence is active.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i/ready_o  fence.t request handshake with commit
//   mask_i[19:0]         flush mask, latched on accept; only [10:0] is used
//   set_pc_commit_o      one-cycle pulse: refetch from the commit PC
//   flush_o[10:0]        one-cycle per-resource flush pulses; bit 4 is always 0
//   flush_dcache_o       D$ flush level, held until flush_dcache_ack_i
//   flush_dcache_ack_i   D$ flush complete
//   halt_o               stalls commit while the fence is active
//   done_o               one-cycle pulse: the fence is complete
//   overrun_o            qualifies done_o: the D$ ack missed the deadline
module fence_t_sequencer #(
  parameter int PAD_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [19:0] mask_i,
  output logic        set_pc_commit_o,
  output logic [10:0] flush_o,
  output logic        flush_dcache_o,
  input  logic        flush_dcache_ack_i,
  output logic        halt_o,
  output logic        done_o,
  output logic        overrun_o
);

  localparam int CNT_W = $clog2(PAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_PAD      = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [10:0]      mask_q;
  logic             overrun_q;

  logic cnt_at_max;
  assign cnt_at_max = (cnt_q == CNT_MAX);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, latched mask and overrun flag. The counter starts at 0 in ISSUE
  // and stops at PAD_CYCLES-1. This keeps the deadline check a simple
  // equality test, even while WAIT_ACK overstays.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          overrun_q <= 1'b0;
          if (req_valid_i) begin
            mask_q <= mask_i[10:0];
          end
        end
        S_ISSUE, S_PAD: begin
          if (!cnt_at_max) cnt_q <= cnt_q + 1'b1;
        end
        S_WAIT_ACK: begin
          if (!cnt_at_max) cnt_q <= cnt_q + 1'b1;
          // The deadline cycle passed without an ack: whatever ack comes
          // later is late.
          if (cnt_at_max && !flush_dcache_ack_i) overrun_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (mask_q[4] && !flush_dcache_ack_i) state_d = S_WAIT_ACK;
        else                                  state_d = S_PAD;
      end
      S_WAIT_ACK: begin
        // An ack on the deadline cycle, or after it, goes straight to DONE.
        // An earlier ack hands the rest of the time to PAD.
        if (flush_dcache_ack_i) begin
          if (overrun_q || cnt_at_max) state_d = S_DONE;
          else                         state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (cnt_at_max) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (Moore: depends only on state and registered data)
  always_comb begin
    req_ready_o     = 1'b0;
    set_pc_commit_o = 1'b0;
    flush_o         = '0;
    flush_dcache_o  = 1'b0;
    halt_o          = 1'b1;
    done_o          = 1'b0;
    overrun_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        halt_o      = 1'b0;
      end
      S_ISSUE: begin
        // The D$ has its own held level, so its pulse bit is masked off.
        flush_o         = mask_q & ~11'h010;
        set_pc_commit_o = |mask_q;
        flush_dcache_o  = mask_q[4];
      end
      S_WAIT_ACK: begin
        flush_dcache_o = 1'b1;
      end
      S_PAD: ;
      S_DONE: begin
        done_o    = 1'b1;
        overrun_o = overrun_q;
      end
      default: begin
        halt_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fence_t_sequencer.sv
// tb/tb_fence_t_sequencer.sv - self-checking bench for fence_t_sequencer
//
// Purpose: drives directed and random fence.t requests. Each cycle it compares
// every output against a timeline model of the fence.
// Ports: none (top-level bench).
module tb_fence_t_sequencer;

  localparam int P = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [19:0] mask_i;
  logic        set_pc_commit_o;
  logic [10:0] flush_o;
  logic        flush_dcache_o;
  logic        flush_dcache_ack_i;
  logic        halt_o;
  logic        done_o;
  logic        overrun_o;

  int errors = 0;
  int checks = 0;

  fence_t_sequencer #(.PAD_CYCLES(P)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .mask_i             (mask_i),
    .set_pc_commit_o    (set_pc_commit_o),
    .flush_o            (flush_o),
    .flush_dcache_o     (flush_dcache_o),
    .flush_dcache_ack_i (flush_dcache_ack_i),
    .halt_o             (halt_o),
    .done_o             (done_o),
    .overrun_o          (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // {ready, set_pc, flush[10:0], dcache, halt, done, overrun}
  logic [16:0] obs;
  assign obs = {req_ready_o, set_pc_commit_o, flush_o, flush_dcache_o,
                halt_o, done_o, overrun_o};

  localparam logic [16:0] IDLE_OUT = 17'h10000;

  // Timeline model. The fence is accepted in cycle 0, and c is the cycle
  // index. If the D$ is flushed, the first ack is taken in cycle a.
  function automatic logic [16:0] model(input int c, input logic [10:0] mk,
                                        input int a, input int done_c,
                                        input bit ov);
    logic        rdy, spc, fdc, hlt, dn, ovo;
    logic [10:0] fl;
    rdy = (c == 0);
    spc = (c == 1) && (mk != 11'h0);
    fl  = (c == 1) ? (mk & 11'h7EF) : 11'h0;
    fdc = mk[4] && (c >= 1) && (c <= a);
    hlt = (c >= 1) && (c <= done_c);
    dn  = (c == done_c);
    ovo = (c == done_c) && ov;
    return {rdy, spc, fl, fdc, hlt, dn, ovo};
  endfunction

  task automatic check(input string tag, input int c, input logic [16:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp_v);
      end
  endtask

  // Runs one complete fence, from the IDLE accept cycle through the done cycle.
  // noise adds random acks where the design must ignore them.
  task automatic run_fence(input string tag, input logic [19:0] m, input int ack_at,
                           input bit noise, input bit hold_valid, input bit idle_ack);
    logic [10:0] mk;
    bit          d, ov, r;
    int          done_c;
    mk = m[10:0];
    d  = mk[4];
    if (d && ack_at > P) begin
      done_c = ack_at + 1;
      ov     = 1'b1;
    end else begin
      done_c = P + 1;
      ov     = 1'b0;
    end
    @(negedge clk_i);
    req_valid_i        = 1'b1;
    mask_i             = m;
    flush_dcache_ack_i = idle_ack | (noise && ($urandom_range(0, 1) == 0));
    check(tag, 0, model(0, mk, ack_at, done_c, ov));
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk_i);
      req_valid_i = hold_valid;
      mask_i      = 20'($urandom);
      r           = noise && ($urandom_range(0, 3) == 0);
      if (d) flush_dcache_ack_i = (c == ack_at) || ((c > ack_at) && r);
      else   flush_dcache_ack_i = r;
      check(tag, c, model(c, mk, ack_at, done_c, ov));
    end
  endtask

  initial begin
    logic [19:0] rm;
    int          ra;
    rst_ni             = 1'b0;
    req_valid_i        = 1'b0;
    mask_i             = '0;
    flush_dcache_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset", 0, IDLE_OUT);
    rst_ni = 1'b1;

    // Reset in the middle of PAD: abort to IDLE, and no done appears later.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    mask_i      = 20'h00081;
    check("t1_accept", 0, model(0, 11'h081, 0, P + 1, 1'b0));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check("t1_run", c, model(c, 11'h081, 0, P + 1, 1'b0));
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("t1_abort", 31, IDLE_OUT);
    for (int c = 32; c < 100; c++) begin
      @(negedge clk_i);
      check("t1_quiet", c, IDLE_OUT);
    end

    run_fence("t2_mask081", 20'h00081, 0, 1'b0, 1'b0, 1'b0);
    run_fence("t3_ack10", 20'h00010, 10, 1'b0, 1'b0, 1'b0);
    run_fence("t4_ack80", 20'h00010, 80, 1'b0, 1'b0, 1'b0);
    run_fence("ack_at_deadline", 20'h00010, P, 1'b0, 1'b0, 1'b0);
    run_fence("ack_after_deadline", 20'h00010, P + 1, 1'b0, 1'b0, 1'b0);
    run_fence("ack_in_issue", 20'h00010, 1, 1'b0, 1'b0, 1'b0);
    run_fence("t5_mask0", 20'h00000, 0, 1'b1, 1'b0, 1'b0);
    run_fence("t5_reserved", 20'hFFFFF, 5, 1'b0, 1'b0, 1'b0);
    // req_valid_i held high: the next accept happens in the cycle after done.
    run_fence("t6_first", 20'h00081, 0, 1'b0, 1'b1, 1'b0);
    run_fence("t6_second", 20'h00002, 0, 1'b0, 1'b1, 1'b1);
    run_fence("t6_third", 20'h00010, 30, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rm = 20'($urandom);
      if ($urandom_range(0, 1) == 0) rm[4] = 1'b1;
      ra = int'($urandom_range(1, 90));
      run_fence("random", rm, ra, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk_i);
    req_valid_i        = 1'b0;
    flush_dcache_ack_i = 1'b0;
    check("final_idle", 0, IDLE_OUT);
    @(negedge clk_i);
    check("final_quiet", 1, IDLE_OUT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
